aes_128_key_expand: RTL

AES_128_KEY_EXPAND -- requirements
Module: aes_128_key_expand

---
 rtl/aes_128_pkg.sv | 29 ++
 rtl/aes_128_sbox.sv | 43 ++++
 rtl/aes_128_key_expand.sv | 118 +++++++++++
 3 files changed

// File: rtl/aes_128_pkg.sv
// Shared constants and types for the AES-128 key-expansion block.
package aes_128_pkg;

  // Number of expansion rounds; round keys are indexed 0..NR.
  localparam int NR = 10;

  // Width of one round key.
  localparam int RK_W = 128;

  // Highest valid round-key index, sized for the 4-bit round pointer.
  localparam logic [3:0] LAST_ROUND = 4'(NR);

  // Last value of the expansion counter before the block becomes ready.
  localparam logic [3:0] LAST_STEP = 4'(NR - 1);

  // Round constants for rounds 1..NR, stored at index 0..NR-1 (top byte only).
  localparam logic [7:0] RCON [NR] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Controller states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_t;

endpackage

// File: rtl/aes_128_sbox.sv
// AES forward S-box: GF(2^8) multiplicative inverse followed by the affine map.
module aes_128_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Inverse as a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0 as required.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] pw;
    logic [7:0] res;
    pw  = a;
    res = 8'h01;
    for (int i = 1; i < 8; i++) begin
      pw  = gf_mul(pw, pw);
      res = gf_mul(res, pw);
    end
    return res;
  endfunction

  // Affine transform: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  logic [7:0] w_inv;

  assign w_inv  = gf_inv(i_byte);
  assign o_byte = affine(w_inv);

endmodule

// File: rtl/aes_128_key_expand.sv
// AES-128 key schedule: expands one cipher key into 11 stored round keys at
// one key per cycle, then serves them by a round pointer.
module aes_128_key_expand
  import aes_128_pkg::*;
(
  input  logic            clk,
  input  logic            kill,
  input  logic [RK_W-1:0] key_in,
  input  logic            key_load,
  input  logic            in_en,
  input  logic            key_ready,
  output logic [RK_W-1:0] key_round,
  output logic [3:0]      round_idx,
  output logic            keys_valid,
  output logic            busy,
  output logic            key_load_collision_irq_pulse
);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_cnt;
  logic [3:0]      r_round_idx;
  logic            r_irq;
  logic [RK_W-1:0] r_work;
  logic [RK_W-1:0] r_rk [0:NR];

  logic            w_expand;
  logic            w_valid;
  logic            w_load;
  logic [31:0]     w_w0, w_w1, w_w2, w_w3;
  logic [31:0]     w_rot, w_sub, w_temp;
  logic [31:0]     w_n0, w_n1, w_n2, w_n3;
  logic [RK_W-1:0] w_next_rk;

  assign w_expand = (r_state == EXPAND);
  assign w_valid  = (r_state == READY);
  // A load arriving mid-expansion is dropped and only flagged.
  assign w_load   = key_load && !w_expand;

  // One FIPS-197 round of the schedule applied to the previous round key.
  assign {w_w0, w_w1, w_w2, w_w3} = r_work;
  assign w_rot = {w_w3[23:0], w_w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_128_sbox u_sbox (
      .i_byte (w_rot[8*g +: 8]),
      .o_byte (w_sub[8*g +: 8])
    );
  end

  assign w_temp    = w_sub ^ {RCON[r_cnt], 24'h000000};
  assign w_n0      = w_w0 ^ w_temp;
  assign w_n1      = w_w1 ^ w_n0;
  assign w_n2      = w_w2 ^ w_n1;
  assign w_n3      = w_w3 ^ w_n2;
  assign w_next_rk = {w_n0, w_n1, w_n2, w_n3};

  // State register.
  always_ff @(posedge clk) begin
    if (kill) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic: load from IDLE/READY, finish after the tenth key.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE, READY: if (key_load) w_state_nxt = EXPAND;
      EXPAND:      if (r_cnt == LAST_STEP) w_state_nxt = READY;
      default:     w_state_nxt = IDLE;
    endcase
  end

  // Expansion counter: number of round keys generated since the load.
  always_ff @(posedge clk) begin
    if (kill)          r_cnt <= 4'd0;
    else if (w_load)   r_cnt <= 4'd0;
    else if (w_expand) r_cnt <= r_cnt + 4'd1;
  end

  // Round-key storage and working key; data only, so never reset.
  always_ff @(posedge clk) begin
    if (!kill) begin
      if (w_load) begin
        r_work   <= key_in;
        r_rk[0]  <= key_in;
      end else if (w_expand) begin
        r_work               <= w_next_rk;
        r_rk[r_cnt + 4'd1]   <= w_next_rk;
      end
    end
  end

  // Round pointer: rewinds on in_en, steps on key_ready, pinned to 0 while invalid.
  always_ff @(posedge clk) begin
    if (kill || w_load || !w_valid) r_round_idx <= 4'd0;
    else if (in_en)                 r_round_idx <= 4'd0;
    else if (key_ready)             r_round_idx <= (r_round_idx == LAST_ROUND) ? 4'd0 : r_round_idx + 4'd1;
  end

  // Collision flag: one cycle after a load request that arrived while busy.
  always_ff @(posedge clk) begin
    if (kill) r_irq <= 1'b0;
    else      r_irq <= key_load && w_expand;
  end

  // Serve the selected round key; stale keys are hidden until the schedule is complete.
  always_comb begin
    key_round = '0;
    if (w_valid && (r_round_idx <= LAST_ROUND)) key_round = r_rk[r_round_idx];
  end

  assign round_idx                    = r_round_idx;
  assign keys_valid                   = w_valid;
  assign busy                         = w_expand;
  assign key_load_collision_irq_pulse = r_irq;

endmodule
